img_buf_arb: RTL and testbench

- Controller and arbiter for the single-port 24-bit image RAM (65536 x RGB888, 256x256 square) that feeds the display timing generator's rd_req/rd_data port.
- Sequences the display read address per frame, realigned on every vsync.
- Shares the RAM with a background loader write port, which is granted only in cycles with no display read.
- Sits between the VGA timing block and the RAM instance, in the vpg_pclk domain.

---
 rtl/img_pkg.sv | 28 ++
 rtl/vs_edge_det.sv | 30 +++
 rtl/img_buf_arb.sv | 130 +++++++++++++
 tb/tb_img_buf_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// ============================================================================
// Module  : img_pkg
// Brief   : Shared image geometry, RAM widths and arbiter state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package img_pkg;

    localparam int SQUARE_X   = 256;
    localparam int SQUARE_Y   = 256;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 24;
    localparam int IMG_PIXELS = SQUARE_X * SQUARE_Y;

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Width needed to hold a count that saturates at n (inclusive).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vs_edge_det.sv
// ============================================================================
// Module  : vs_edge_det
// Brief   : Registers active-low vsync and pulses on its falling edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vs_edge_det (
    input  logic vpg_pclk,
    input  logic rst,
    input  logic i_vs,
    output logic o_fs
);

    logic r_vs_d;

    // Resetting high means a vsync already low at reset release counts as a frame start.
    always_ff @(posedge vpg_pclk) begin
        if (rst) begin
            r_vs_d <= 1'b1;
        end else begin
            r_vs_d <= i_vs;
        end
    end

    assign o_fs = r_vs_d & ~i_vs;

endmodule

`default_nettype wire

// File: rtl/img_buf_arb.sv
// ============================================================================
// Module  : img_buf_arb
// Brief   : Image RAM controller: per-frame display read sequencing with
//           loader writes granted only in cycles free of display reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module img_buf_arb #(
    parameter int ADDR_W     = img_pkg::ADDR_W,
    parameter int DATA_W     = img_pkg::DATA_W,
    parameter int IMG_PIXELS = img_pkg::IMG_PIXELS
) (
    input  logic              vpg_pclk,
    input  logic              rst,
    input  logic              vpg_vs,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              frame_err,
    output logic              synced
);

    import img_pkg::*;

    localparam int                 c_CNT_W   = cnt_width(IMG_PIXELS);
    localparam logic [c_CNT_W-1:0] c_IMG_CNT = c_CNT_W'(IMG_PIXELS);

    state_t              r_state;
    logic                r_synced;
    logic                r_frame_err;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [c_CNT_W-1:0]  r_rd_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_wr_ack;
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_fs;
    logic                w_rd_go;
    logic                w_wr_go;

    vs_edge_det u_vs_edge_det (
        .vpg_pclk (vpg_pclk),
        .rst      (rst),
        .i_vs     (vpg_vs),
        .o_fs     (w_fs)
    );

    assign w_rd_go = (r_state == S_RUN) && rd_req;
    // wr_req during the ack cycle still shows the word just issued, so it is not re-granted.
    assign w_wr_go = wr_req && !r_wr_ack && !w_rd_go;

    always_ff @(posedge vpg_pclk) begin
        if (rst) begin
            r_state     <= S_WAIT;
            r_synced    <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_cnt    <= '0;
        end else begin
            if (w_fs) begin
                r_state  <= S_RUN;
                r_synced <= 1'b1;
                if (r_synced && (r_rd_cnt != c_IMG_CNT)) begin
                    r_frame_err <= 1'b1;
                end
                // A read coinciding with frame start consumes address 0.
                r_rd_addr <= w_rd_go ? ADDR_W'(1)  : '0;
                r_rd_cnt  <= w_rd_go ? c_CNT_W'(1) : '0;
            end else if (w_rd_go) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                if (r_rd_cnt != c_IMG_CNT) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vpg_pclk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wr_ack    <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_wr_ack <= w_wr_go;
            if (w_rd_go) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_fs ? '0 : r_rd_addr;
            end else if (w_wr_go) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end
            if (r_mem_en && !r_mem_we) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign wr_ack    = r_wr_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign frame_err = r_frame_err;
    assign synced    = r_synced;

endmodule

`default_nettype wire

// File: tb/tb_img_buf_arb.sv
// ============================================================================
// Module  : tb_img_buf_arb
// Brief   : Self-checking bench for img_buf_arb with a behavioural RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_img_buf_arb;

    localparam int AW     = 16;
    localparam int DW     = 24;
    localparam int TB_IMG = 256;

    logic          vpg_pclk = 1'b0;
    logic          rst      = 1'b1;
    logic          vpg_vs   = 1'b1;
    logic          rd_req   = 1'b0;
    logic          wr_req   = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic [DW-1:0] rd_data;
    logic          wr_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          frame_err;
    logic          synced;

    always #5 vpg_pclk = ~vpg_pclk;

    img_buf_arb #(.ADDR_W(AW), .DATA_W(DW), .IMG_PIXELS(TB_IMG)) dut (
        .vpg_pclk  (vpg_pclk),
        .rst       (rst),
        .vpg_vs    (vpg_vs),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .frame_err (frame_err),
        .synced    (synced)
    );

    logic [DW-1:0] ram [0:65535];
    always @(posedge vpg_pclk) if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = (mem_en && !mem_we) ? ram[mem_addr] : 24'hDEAD00;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic summary_and_stop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
            if (n_fail >= 200) summary_and_stop();
        end
    endtask

    // Reference model: frame bookkeeping, its own copy of RAM contents,
    // and the outputs expected after each clock edge.
    logic [DW-1:0] m_mem [0:65535];
    bit            m_vs_d = 1, m_run = 0, m_syn = 0, m_ferr = 0, m_prev_ack = 0, m_pend = 0;
    int            m_addr = 0, m_cnt = 0;
    logic [DW-1:0] m_pend_val = '0;
    bit            e_en = 0, e_we = 0, e_ack = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0, e_rd = '0;

    task automatic model_step();
        bit fs, rd, wr;
        int use_addr;
        if (rst) begin
            m_vs_d = 1; m_run = 0; m_syn = 0; m_ferr = 0; m_prev_ack = 0; m_pend = 0;
            m_addr = 0; m_cnt = 0;
            e_en = 0; e_we = 0; e_ack = 0; e_rd = '0;
            return;
        end
        fs     = m_vs_d && !vpg_vs;
        m_vs_d = vpg_vs;
        if (m_pend) e_rd = m_pend_val;
        rd = m_run && rd_req;
        wr = !rd && wr_req && !m_prev_ack;
        m_pend = 0;
        if (rd) begin
            use_addr   = fs ? 0 : m_addr;
            e_en = 1; e_we = 0; e_ack = 0; e_addr = AW'(use_addr);
            m_pend     = 1;
            m_pend_val = m_mem[use_addr];
        end else if (wr) begin
            e_en = 1; e_we = 1; e_ack = 1; e_addr = wr_addr; e_wd = wr_data;
            m_mem[wr_addr] = wr_data;
        end else begin
            e_en = 0; e_we = 0; e_ack = 0;
        end
        m_prev_ack = wr;
        if (fs) begin
            if (m_syn && m_cnt != TB_IMG) m_ferr = 1;
            m_syn  = 1;
            m_run  = 1;
            m_addr = rd ? 1 : 0;
            m_cnt  = rd ? 1 : 0;
        end else if (rd) begin
            m_addr = (m_addr + 1) % 65536;
            m_cnt  = (m_cnt < TB_IMG) ? m_cnt + 1 : TB_IMG;
        end
    endtask

    task automatic tick();
        bit ok;
        @(posedge vpg_pclk);
        model_step();
        #1;
        cyc++;
        ok = (mem_en === e_en) && (mem_we === e_we) && (wr_ack === e_ack) &&
             (synced === m_syn) && (frame_err === m_ferr) && (rd_data === e_rd) &&
             (!e_en || mem_addr === e_addr) && (!e_we || mem_wdata === e_wd);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL model cycle %0d: got en=%b we=%b addr=%h wd=%h ack=%b syn=%b ferr=%b rd=%h, expected en=%b we=%b addr=%h wd=%h ack=%b syn=%b ferr=%b rd=%h",
                     cyc, mem_en, mem_we, mem_addr, mem_wdata, wr_ack, synced, frame_err, rd_data,
                     e_en, e_we, e_addr, e_wd, e_ack, m_syn, m_ferr, e_rd);
            if (n_fail >= 200) summary_and_stop();
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit rd, input bit wr);
        rst = r; vpg_vs = v; rd_req = rd; wr_req = wr;
    endtask

    typedef struct {
        bit            r, v, rd, wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            en, we;
        logic [AW-1:0] addr;
        bit            ack, syn, ferr;
        logic [DW-1:0] rdd;
    } vec_t;

    vec_t tbl [14];

    bit r_upd = 0;
    task automatic loader_rand();
        if (r_upd) begin
            if ($urandom_range(0, 1) == 0) wr_req = 0;
            else begin
                wr_req = 1; wr_addr = AW'($urandom_range(0, 511)); wr_data = DW'($urandom);
            end
        end else if (!wr_req && $urandom_range(0, 2) == 0) begin
            wr_req = 1; wr_addr = AW'($urandom_range(0, 511)); wr_data = DW'($urandom);
        end
    endtask

    initial begin
        int acks;
        int frame_len [5];
        for (int a = 0; a < 65536; a++) begin
            ram[a]   = DW'(a);
            m_mem[a] = DW'(a);
        end

        //            r  v  rd wr wa        wd           en we addr      ack syn ferr rdd
        tbl[0]  = '{1, 1, 0, 0, 16'h0000, 24'h000000, 0, 0, 16'h0000, 0, 0, 0, 24'h000000};
        tbl[1]  = '{0, 1, 1, 0, 16'h0000, 24'h000000, 0, 0, 16'h0000, 0, 0, 0, 24'h000000};
        tbl[2]  = '{0, 1, 1, 1, 16'h8010, 24'h111111, 1, 1, 16'h8010, 1, 0, 0, 24'h000000};
        tbl[3]  = '{0, 1, 0, 1, 16'h8010, 24'h111111, 0, 0, 16'h0000, 0, 0, 0, 24'h000000};
        tbl[4]  = '{0, 1, 0, 0, 16'h0000, 24'h000000, 0, 0, 16'h0000, 0, 0, 0, 24'h000000};
        tbl[5]  = '{0, 0, 1, 0, 16'h0000, 24'h000000, 0, 0, 16'h0000, 0, 1, 0, 24'h000000};
        tbl[6]  = '{0, 0, 1, 0, 16'h0000, 24'h000000, 1, 0, 16'h0000, 0, 1, 0, 24'h000000};
        tbl[7]  = '{0, 0, 1, 1, 16'h8020, 24'h222222, 1, 0, 16'h0001, 0, 1, 0, 24'h000000};
        tbl[8]  = '{0, 0, 0, 1, 16'h8020, 24'h222222, 1, 1, 16'h8020, 1, 1, 0, 24'h000001};
        tbl[9]  = '{0, 1, 1, 1, 16'h8020, 24'h222222, 1, 0, 16'h0002, 0, 1, 0, 24'h000001};
        tbl[10] = '{0, 1, 0, 0, 16'h0000, 24'h000000, 0, 0, 16'h0000, 0, 1, 0, 24'h000002};
        tbl[11] = '{0, 0, 1, 0, 16'h0000, 24'h000000, 1, 0, 16'h0000, 0, 1, 1, 24'h000002};
        tbl[12] = '{0, 0, 1, 0, 16'h0000, 24'h000000, 1, 0, 16'h0001, 0, 1, 1, 24'h000000};
        tbl[13] = '{0, 0, 0, 0, 16'h0000, 24'h000000, 0, 0, 16'h0000, 0, 1, 1, 24'h000001};

        drive(1, 1, 0, 0);
        tick(); tick();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].rd, tbl[i].wr);
            wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            tick();
            chk($sformatf("vec%0d", i),
                {mem_en, mem_we, (tbl[i].en ? mem_addr : 16'h0), wr_ack, synced, frame_err, rd_data},
                {tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].ack, tbl[i].syn, tbl[i].ferr, tbl[i].rdd});
        end
        chk("ram_8010", ram[16'h8010], 24'h111111);
        chk("ram_8020", ram[16'h8020], 24'h222222);

        // Sequential burst from frame start, RAM holding addr == data.
        drive(1, 1, 0, 0); tick(); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
        chk("synced_after_fs", synced, 1);
        for (int k = 0; k < 256; k++) begin
            rd_req = 1; tick();
            chk("burst_addr", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, AW'(k)});
            if (k > 0) chk("burst_data", rd_data, DW'(k - 1));
        end
        rd_req = 0; tick();
        chk("burst_last", rd_data, 24'h0000FF);

        // Frame start coinciding with a read while rd_addr is 0x0100.
        vpg_vs = 1; tick();
        vpg_vs = 0; rd_req = 1; tick();
        chk("fs_rd_addr0", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0000});
        chk("good_frame_no_err", frame_err, 0);
        tick();
        chk("fs_rd_next", mem_addr, 16'h0001);
        for (int k = 0; k < TB_IMG - 3; k++) tick();
        rd_req = 0; tick();
        vpg_vs = 1; tick();
        vpg_vs = 0; tick();
        chk("short_frame_err", frame_err, 1);
        for (int k = 0; k < TB_IMG; k++) begin rd_req = 1; tick(); end
        rd_req = 0; vpg_vs = 1; tick();
        vpg_vs = 0; tick();
        chk("err_sticky", frame_err, 1);

        // Held write starved by a 10-cycle read burst.
        acks = 0;
        wr_req = 1; wr_addr = 16'h1234; wr_data = 24'hABCDEF;
        for (int k = 0; k < 10; k++) begin
            rd_req = 1; tick();
            chk("starved_we", mem_we, 0);
            acks += int'(wr_ack);
        end
        rd_req = 0; tick();
        chk("drain_write", {mem_en, mem_we, mem_addr, mem_wdata, wr_ack},
            {1'b1, 1'b1, 16'h1234, 24'hABCDEF, 1'b1});
        acks += int'(wr_ack);
        tick();
        chk("no_regrant", {mem_en, wr_ack}, 2'b00);
        acks += int'(wr_ack);
        wr_req = 0; tick();
        acks += int'(wr_ack);
        chk("single_ack", acks, 1);
        chk("write_landed", ram[16'h1234], 24'hABCDEF);

        // Reset mid-burst with a write pending.
        wr_req = 1; wr_addr = 16'h2222; wr_data = 24'h123456;
        rd_req = 1; tick(); tick();
        rst = 1; tick();
        chk("rst_outputs", {rd_data, wr_ack, mem_en, mem_we, mem_addr, mem_wdata, frame_err, synced},
            {24'h0, 1'b0, 1'b0, 1'b0, 16'h0, 24'h0, 1'b0, 1'b0});
        drive(0, 1, 1, 0); tick();
        chk("post_rst_wait", {synced, mem_en}, 2'b00);
        tick();
        vpg_vs = 0; tick();
        chk("resync", {synced, mem_en}, 2'b10);
        rd_req = 0; tick();

        // Randomised frames checked against the model.
        frame_len = '{TB_IMG, TB_IMG - 1, TB_IMG + 3, TB_IMG, 0};
        for (int f = 0; f < 40; f++) begin
            int n, done;
            n = (f % 5 == 4) ? $urandom_range(50, 300) : frame_len[f % 5];
            done = 0;
            while (done < n) begin
                rd_req = ($urandom_range(0, 3) != 0);
                rst    = ($urandom_range(0, 1999) == 0);
                if (rd_req) done++;
                loader_rand();
                tick();
                r_upd = wr_ack;
            end
            rst = 0;
            for (int k = 0; k < 3; k++) begin
                vpg_vs = (k < 2);
                rd_req = ($urandom_range(0, 1) == 0);
                loader_rand();
                tick();
                r_upd = wr_ack;
            end
        end

        summary_and_stop();
    end

endmodule

`default_nettype wire
